// File: rtl/st_buffer_pkg.sv
// Shared CPU store/load package.
// Holds the store funct3 encodings and the byte-enable width, which the
// store buffer and the load filter both use. It also defines the
// store-buffer entry layout.
package st_buffer_pkg;

  // RISC-V store width encodings (funct3 field)
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  // One byte enable per byte lane of the 32-bit data bus
  localparam int BE_W = 4;

  // A queued store: word address, lane-aligned data and byte enables
  typedef struct packed {
    logic [31:0]     addr;
    logic [31:0]     wdata;
    logic [BE_W-1:0] be;
  } st_entry_t;

endpackage

// File: rtl/st_buffer_align.sv
// st_align: combinational store alignment. This is the store-side mirror
// of the load filter.
// Ports:
//   funct3   - store width (SB/SH/SW)
//   addr     - byte address
//   rs2_data - LSB-justified store data
//   be       - byte enables for the addressed word
//   wdata    - data replicated onto every lane it may occupy
//   fault    - misaligned access or unsupported funct3
module st_align
  import st_buffer_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [31:0]     addr,
  input  logic [31:0]     rs2_data,
  output logic [BE_W-1:0] be,
  output logic [31:0]     wdata,
  output logic            fault
);

  // Data is replicated across lanes, so only the byte enables depend on the
  // low address bits. A faulting store reports zero enables, which keeps a
  // bad store harmless even if someone forgets to check fault.
  always_comb begin
    be    = '0;
    wdata = '0;
    fault = 1'b0;
    case (funct3)
      F3_SB: begin
        be    = 4'b0001 << addr[1:0];
        wdata = {4{rs2_data[7:0]}};
      end
      F3_SH: begin
        wdata = {2{rs2_data[15:0]}};
        if (addr[0]) begin
          fault = 1'b1;
        end else begin
          be = addr[1] ? 4'b1100 : 4'b0011;
        end
      end
      F3_SW: begin
        wdata = rs2_data;
        if (addr[1:0] != 2'b00) begin
          fault = 1'b1;
        end else begin
          be = 4'b1111;
        end
      end
      default: fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/st_buffer.sv
// st_buffer: in-order store buffer between the MEM stage and data memory.
// Ports:
//   clk, rst          - clock; synchronous active-high reset
//   st_valid/st_ready - store handshake from the MEM stage
//   funct3, addr, rs2_data - store description
//   mem_req/mem_gnt   - head-of-queue write handshake to data memory
//   mem_addr/mem_wdata/mem_be - head entry (all zero while empty)
//   misaligned        - one-cycle pulse after a rejected store
//   empty             - nothing pending (fence/drain indication)
module st_buffer
  import st_buffer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            st_valid,
  output logic            st_ready,
  input  logic [2:0]      funct3,
  input  logic [31:0]     addr,
  input  logic [31:0]     rs2_data,
  output logic            mem_req,
  input  logic            mem_gnt,
  output logic [31:0]     mem_addr,
  output logic [31:0]     mem_wdata,
  output logic [BE_W-1:0] mem_be,
  output logic            misaligned,
  output logic            empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             misaligned_q, misaligned_d;
  st_entry_t        entries_q [DEPTH];
  st_entry_t        entries_d [DEPTH];

  logic [BE_W-1:0] al_be;
  logic [31:0]     al_wdata;
  logic            al_fault;
  logic            accept;
  logic            enq;
  logic            deq;
  st_entry_t       head;

  st_align u_align (
    .funct3   (funct3),
    .addr     (addr),
    .rs2_data (rs2_data),
    .be       (al_be),
    .wdata    (al_wdata),
    .fault    (al_fault)
  );

  // st_ready depends only on registered count, never on mem_gnt. A grant
  // with nothing pending is ignored. A rejected store is still "accepted"
  // (it is consumed from the pipeline) but never enters the queue.
  always_comb begin
    st_ready = (count_q != FULL_CNT);
    mem_req  = (count_q != '0);
    empty    = (count_q == '0);
    accept   = st_valid && st_ready;
    enq      = accept && !al_fault;
    deq      = mem_gnt && mem_req;
  end

  // FIFO next-state. The pointers wrap naturally because DEPTH is a power
  // of two. A simultaneous push and pop leaves the count unchanged. The push
  // always targets a free slot, so it cannot clobber the head being popped.
  always_comb begin
    entries_d    = entries_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    misaligned_d = accept && al_fault;
    if (enq) begin
      entries_d[wr_ptr_q] = '{addr:  {addr[31:2], 2'b00},
                              wdata: al_wdata,
                              be:    al_be};
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (deq) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State register. Reset wipes every entry so nothing stale can resurface.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      misaligned_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      misaligned_q <= misaligned_d;
      entries_q    <= entries_d;
    end
  end

  // The head is presented only while something is pending. The slot behind
  // the read pointer may still hold an already-issued store, so it is masked
  // when the buffer is empty.
  always_comb begin
    head       = entries_q[rd_ptr_q];
    misaligned = misaligned_q;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_be     = '0;
    if (count_q != '0) begin
      mem_addr  = head.addr;
      mem_wdata = head.wdata;
      mem_be    = head.be;
    end
  end

endmodule

// File: tb/tb_st_buffer.sv
// Testbench for st_buffer. Directed stores are driven from the main initial
// block, and each expected memory write is queued at that point. A monitor
// pops the queue whenever the DUT completes a write handshake.
module tb_st_buffer;
  import st_buffer_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            st_valid;
  logic            st_ready;
  logic [2:0]      funct3;
  logic [31:0]     addr;
  logic [31:0]     rs2_data;
  logic            mem_req;
  logic            mem_gnt;
  logic [31:0]     mem_addr;
  logic [31:0]     mem_wdata;
  logic [BE_W-1:0] mem_be;
  logic            misaligned;
  logic            empty;

  int checks   = 0;
  int failures = 0;

  st_entry_t exp_q[$];

  st_buffer #(.DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .st_valid   (st_valid),
    .st_ready   (st_ready),
    .funct3     (funct3),
    .addr       (addr),
    .rs2_data   (rs2_data),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .misaligned (misaligned),
    .empty      (empty)
  );

  // 10-unit clock
  always #5 clk = ~clk;

  // Single comparison point: every check goes through here
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drive the store-side inputs; they are sampled at the next rising edge
  task automatic applyStimulus(input logic v, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] d);
    st_valid = v;
    funct3   = f3;
    addr     = a;
    rs2_data = d;
  endtask

  // Advance one edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExpected(input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] b);
    st_entry_t e;
    e.addr  = a;
    e.wdata = d;
    e.be    = b;
    exp_q.push_back(e);
  endtask

  // Monitor: a write completes on the edge following a falling edge where
  // mem_req and mem_gnt are both high. Any write that the scoreboard does
  // not expect is an error.
  always @(negedge clk) begin
    if (!rst && mem_req && mem_gnt) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_write", mem_addr, 32'hFFFF_FFFF);
      end else begin
        st_entry_t e;
        e = exp_q.pop_front();
        checkOutput("wr_addr", mem_addr, e.addr);
        checkOutput("wr_data", mem_wdata, e.wdata);
        checkOutput("wr_be", {28'h0, mem_be}, {28'h0, e.be});
      end
    end
  end

  // Watchdog so the bench never hangs
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence
  initial begin
    rst     = 1'b1;
    mem_gnt = 1'b0;
    applyStimulus(1'b0, 3'b000, 32'h0, 32'h0);
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    checkOutput("rst_mem_req", {31'h0, mem_req}, 32'h0);
    checkOutput("rst_empty", {31'h0, empty}, 32'h1);
    checkOutput("rst_st_ready", {31'h0, st_ready}, 32'h1);
    checkOutput("rst_mem_be", {28'h0, mem_be}, 32'h0);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
    checkOutput("rst_misaligned", {31'h0, misaligned}, 32'h0);

    // SB to byte lane 3, with grant already high
    mem_gnt = 1'b1;
    pushExpected(32'h1000, 32'hABAB_ABAB, 4'b1000);
    applyStimulus(1'b1, F3_SB, 32'h1003, 32'h0000_00AB);
    tick();
    applyStimulus(1'b0, F3_SB, 32'h0, 32'h0);
    checkOutput("sb_mem_req", {31'h0, mem_req}, 32'h1);
    checkOutput("sb_mem_be", {28'h0, mem_be}, 32'h8);
    tick();
    checkOutput("sb_drained", {31'h0, empty}, 32'h1);
    checkOutput("sb_empty_addr", mem_addr, 32'h0);

    // SH to the upper half-word
    pushExpected(32'h2000, 32'hBEEF_BEEF, 4'b1100);
    applyStimulus(1'b1, F3_SH, 32'h2002, 32'h1234_BEEF);
    tick();
    applyStimulus(1'b0, F3_SB, 32'h0, 32'h0);
    checkOutput("sh_mem_be", {28'h0, mem_be}, 32'hC);
    checkOutput("sh_mem_wdata", mem_wdata, 32'hBEEF_BEEF);
    tick();

    // Misaligned SH: pulse for one cycle, nothing enqueued
    applyStimulus(1'b1, F3_SH, 32'h2001, 32'h1234_BEEF);
    tick();
    applyStimulus(1'b0, F3_SB, 32'h0, 32'h0);
    checkOutput("sh_mis_pulse", {31'h0, misaligned}, 32'h1);
    checkOutput("sh_mis_no_req", {31'h0, mem_req}, 32'h0);
    tick();
    checkOutput("sh_mis_cleared", {31'h0, misaligned}, 32'h0);
    checkOutput("sh_mis_still_empty", {31'h0, empty}, 32'h1);

    // Misaligned SW and an unsupported funct3 are also rejected
    applyStimulus(1'b1, F3_SW, 32'h3002, 32'hDEAD_BEEF);
    tick();
    checkOutput("sw_mis_pulse", {31'h0, misaligned}, 32'h1);
    applyStimulus(1'b1, 3'b011, 32'h3000, 32'hDEAD_BEEF);
    tick();
    applyStimulus(1'b0, F3_SB, 32'h0, 32'h0);
    checkOutput("f3_bad_pulse", {31'h0, misaligned}, 32'h1);
    checkOutput("f3_bad_no_req", {31'h0, mem_req}, 32'h0);
    tick();

    // Three back-to-back SW with no grant: the buffer fills after two and the
    // third store is held
    mem_gnt = 1'b0;
    pushExpected(32'h10, 32'h1111_1111, 4'hF);
    pushExpected(32'h14, 32'h2222_2222, 4'hF);
    pushExpected(32'h18, 32'h3333_3333, 4'hF);
    applyStimulus(1'b1, F3_SW, 32'h10, 32'h1111_1111);
    tick();
    applyStimulus(1'b1, F3_SW, 32'h14, 32'h2222_2222);
    tick();
    checkOutput("full_not_ready", {31'h0, st_ready}, 32'h0);
    applyStimulus(1'b1, F3_SW, 32'h18, 32'h3333_3333);
    tick();
    checkOutput("full_still_not_ready", {31'h0, st_ready}, 32'h0);
    checkOutput("full_head_stable", mem_addr, 32'h10);
    mem_gnt = 1'b1;
    tick();
    tick();
    applyStimulus(1'b0, F3_SB, 32'h0, 32'h0);
    checkOutput("held_store_at_head", mem_addr, 32'h18);
    tick();
    checkOutput("full_drained", {31'h0, empty}, 32'h1);

    // Push and pop on the same edge at count 1
    mem_gnt = 1'b0;
    pushExpected(32'h40, 32'h4444_4444, 4'hF);
    pushExpected(32'h44, 32'h5555_5555, 4'hF);
    applyStimulus(1'b1, F3_SW, 32'h40, 32'h4444_4444);
    tick();
    applyStimulus(1'b1, F3_SW, 32'h44, 32'h5555_5555);
    mem_gnt = 1'b1;
    tick();
    applyStimulus(1'b0, F3_SB, 32'h0, 32'h0);
    mem_gnt = 1'b0;
    checkOutput("simul_head", mem_addr, 32'h44);
    checkOutput("simul_req", {31'h0, mem_req}, 32'h1);
    checkOutput("simul_count1_ready", {31'h0, st_ready}, 32'h1);
    mem_gnt = 1'b1;
    tick();
    checkOutput("simul_drained", {31'h0, empty}, 32'h1);

    // Reset with two stores pending discards them. A store presented during
    // the reset edge must also be dropped.
    mem_gnt = 1'b0;
    applyStimulus(1'b1, F3_SW, 32'h80, 32'h8888_8888);
    tick();
    applyStimulus(1'b1, F3_SW, 32'h84, 32'h9999_9999);
    tick();
    checkOutput("pre_rst_full", {31'h0, st_ready}, 32'h0);
    rst = 1'b1;
    mem_gnt = 1'b1;
    applyStimulus(1'b1, F3_SW, 32'h88, 32'h7777_7777);
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, F3_SB, 32'h0, 32'h0);
    checkOutput("post_rst_req", {31'h0, mem_req}, 32'h0);
    checkOutput("post_rst_empty", {31'h0, empty}, 32'h1);
    checkOutput("post_rst_be", {28'h0, mem_be}, 32'h0);
    tick();
    tick();
    tick();
    checkOutput("post_rst_no_stale", {31'h0, mem_req}, 32'h0);

    // Every expected write must have been observed
    checkOutput("scoreboard_empty", exp_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
